uart_tx_buf: RTL

- Transmit-side counterpart of the UART receive flag buffer.
- Accepts one byte from the host into a holding register and raises a full flag. Serialises the byte as an 8N1-style frame on tx, paced by the shared 16x oversampling baud tick.
- Provides double buffering: the host may load the next byte while the current one shifts out.
- Sits between the cipher datapath (byte producer) and the FPGA TX pin.

---
 rtl/uart_tx_buf.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - double-buffered 8N1-style UART transmitter paced by a 16x baud tick
module uart_tx_buf #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic [DBIT-1:0] din,
    input  logic            s_tick,
    output logic            full,
    output logic            tx,
    output logic            tx_done_tick
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [5:0] BIT_LAST  = 6'd15;
    localparam logic [5:0] STOP_LAST = 6'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

    state_t          state_q, state_d;
    logic [5:0]      s_cnt_q, s_cnt_d;
    logic [2:0]      n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] hold_q, hold_d;
    logic            full_q, full_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_q     <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_q     <= b_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_d     = b_q;
        hold_d  = hold_q;
        full_d  = full_q;
        done_d  = 1'b0;

        // A write is only taken while the holding register is empty, so it
        // can never collide with the IDLE transfer, which requires it full.
        if (wr && !full_q) begin
            hold_d = din;
            full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (full_q) begin
                    b_d     = hold_q;
                    full_d  = 1'b0;
                    s_cnt_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        state_d = DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + 6'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        b_d     = b_q >> 1;
                        if (n_cnt_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + 3'd1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 6'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the upcoming state so the pin flop never glitches.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign full         = full_q;
    assign tx           = tx_q;
    assign tx_done_tick = done_q;

endmodule
